// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared widths, FSM encoding and the byte-merge helper
// for the cache<->memory responder.
package mem_responder_pkg;

   localparam int MEM_DATA_BITS = 128;
   localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

   // Request-side FSM: IDLE takes requests, WAIT_DATA holds a write address
   // until its data beat arrives.
   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_DATA = 1'b1
   } state_e;

   // Replace each byte of old_line whose mask bit is set with the same byte of new_line.
   function automatic logic [MEM_DATA_BITS-1:0] merge_bytes(
      input logic [MEM_DATA_BITS-1:0] old_line,
      input logic [MEM_DATA_BITS-1:0] new_line,
      input logic [MEM_MASK_BITS-1:0] mask
   );
      logic [MEM_DATA_BITS-1:0] res;
      res = old_line;
      for (int i = 0; i < MEM_MASK_BITS; i++) begin
         if (mask[i]) res[8*i +: 8] = new_line[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_responder_resp_pipe.sv
// mem_resp_pipe: LATENCY-deep valid+data delay line with synchronous flush.
// Each data stage only loads when the stage before it is valid, so the last
// stage keeps the most recent response while its valid is low.
module mem_resp_pipe #(
   parameter int LATENCY = 4,
   parameter int W       = 128
) (
   input  logic         clk,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [LATENCY-1:0]        valid_q, valid_d;
   logic [LATENCY-1:0][W-1:0] data_q,  data_d;

   // Shift valids every cycle; carry data only behind a valid; flush clears all stages.
   always_comb begin
      valid_d    = '0;
      data_d     = data_q;
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = in_data;
      for (int k = 1; k < LATENCY; k++) begin
         valid_d[k] = valid_q[k-1];
         if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
      if (flush) begin
         valid_d = '0;
         data_d  = '0;
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
      data_q  <= data_d;
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: backing-store slave for the cache<->memory request interface.
// Reads return after a fixed latency, strictly in order; writes commit under a
// byte mask either with the request or once a delayed data beat arrives.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; ready never waits on the peer's valid except that the data
// channel is only opened in IDLE while a write request is presented.
// Optional build macro MEM_RESPONDER_RAND_STALL_EN: LFSR-driven random stalls
// on both ready outputs (never on the response).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_BITS  = 28,
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_req_valid,
   output logic                     mem_req_ready,
   input  logic [ADDR_BITS-1:0]     mem_req_addr,
   input  logic                     mem_req_rw,
   input  logic                     mem_req_data_valid,
   output logic                     mem_req_data_ready,
   input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
   input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
   output logic                     mem_resp_valid,
   output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   state_e                   state_q, state_d;
   logic [DEPTH_LOG2-1:0]    wr_idx_q, wr_idx_d;
   logic                     rd_valid_q, rd_valid_d;
   logic [MEM_DATA_BITS-1:0] rd_data_q, rd_data_d;

   logic [MEM_DATA_BITS-1:0] mem [0:DEPTH-1];

   logic                     stall;
   logic                     wr_en;
   logic [DEPTH_LOG2-1:0]    wr_idx;
   logic [MEM_DATA_BITS-1:0] wr_line;
   logic [DEPTH_LOG2-1:0]    req_idx;
   logic                     unused_addr_hi;

   // Upper address bits alias onto the stored lines.
   assign req_idx        = mem_req_addr[DEPTH_LOG2-1:0];
   assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

`ifdef MEM_RESPONDER_RAND_STALL_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11, advancing every cycle.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR register, reseeded on reset.
   always_ff @(posedge clk) begin
      lfsr_q <= reset ? LFSR_SEED : lfsr_d;
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Request FSM: handshakes, write commit selection and read capture.
   always_comb begin
      state_d            = state_q;
      wr_idx_d           = wr_idx_q;
      rd_valid_d         = 1'b0;
      rd_data_d          = rd_data_q;
      mem_req_ready      = 1'b0;
      mem_req_data_ready = 1'b0;
      wr_en              = 1'b0;
      wr_idx             = req_idx;
      case (state_q)
         ST_IDLE: begin
            mem_req_ready      = ~reset & ~stall;
            mem_req_data_ready = ~reset & ~stall & mem_req_valid & mem_req_rw;
            if (mem_req_valid && mem_req_ready) begin
               if (mem_req_rw) begin
                  if (mem_req_data_valid) begin
                     wr_en = 1'b1;
                  end else begin
                     wr_idx_d = req_idx;
                     state_d  = ST_WAIT_DATA;
                  end
               end else begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = mem[req_idx];
               end
            end
         end
         ST_WAIT_DATA: begin
            mem_req_data_ready = ~reset & ~stall;
            wr_idx             = wr_idx_q;
            if (mem_req_data_valid && mem_req_data_ready) begin
               wr_en   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      wr_line = merge_bytes(mem[wr_idx], mem_req_data_bits, mem_req_data_mask);
   end

   // FSM and read-capture registers; reset aborts a pending write without commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wr_idx_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_idx_q   <= wr_idx_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Line storage, byte-masked write; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_line;
   end

   // Captured read sits in rd_*_q for one edge, then LATENCY-1 more stages.
   mem_resp_pipe #(
      .LATENCY (LATENCY),
      .W       (MEM_DATA_BITS)
   ) u_resp_pipe (
      .clk       (clk),
      .flush     (reset),
      .in_valid  (rd_valid_q),
      .in_data   (rd_data_q),
      .out_valid (mem_resp_valid),
      .out_data  (mem_resp_data)
   );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder (default build).
module tb_mem_responder;

   localparam int LAT = 4;

   logic         clk;
   logic         reset;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [27:0]  mem_req_addr;
   logic         mem_req_rw;
   logic         mem_req_data_valid;
   logic         mem_req_data_ready;
   logic [127:0] mem_req_data_bits;
   logic [15:0]  mem_req_data_mask;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [127:0] exp_q[$];
   int           cyc_q[$];

   mem_responder #(
      .ADDR_BITS  (28),
      .DEPTH_LOG2 (12),
      .LATENCY    (LAT)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_addr       (mem_req_addr),
      .mem_req_rw         (mem_req_rw),
      .mem_req_data_valid (mem_req_data_valid),
      .mem_req_data_ready (mem_req_data_ready),
      .mem_req_data_bits  (mem_req_data_bits),
      .mem_req_data_mask  (mem_req_data_mask),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_data      (mem_resp_data)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkint(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every response must match the oldest expectation, on its cycle
   always @(negedge clk) begin
      if (mem_resp_valid) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_resp observed=%h expected=none", mem_resp_data);
         end
         if (exp_q.size() != 0) begin
            logic [127:0] d;
            int           c;
            d = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk128("resp_data", mem_resp_data, d);
            chkint("resp_cycle", cyc, c);
         end
      end
   end

   // Driver: write with data in the same cycle; called and returns at a negedge
   task automatic do_write(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
      bit fire;
      bit done;
      done = 1'b0;
      mem_req_valid      = 1'b1;
      mem_req_rw         = 1'b1;
      mem_req_addr       = addr;
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = data;
      mem_req_data_mask  = mask;
      for (int i = 0; i < 64 && !done; i++) begin
         #1;
         fire = mem_req_ready && mem_req_data_ready;
         @(negedge clk);
         if (fire) done = 1'b1;
      end
      mem_req_valid      = 1'b0;
      mem_req_data_valid = 1'b0;
      chk1("wr_accept", done, 1'b1);
   endtask

   // Driver: read request; queues the expected data and response cycle
   task automatic issue_read(input logic [27:0] addr, input logic [127:0] exp, output int acc_cyc);
      bit fire;
      bit done;
      done = 1'b0;
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = addr;
      for (int i = 0; i < 64 && !done; i++) begin
         #1;
         fire = mem_req_ready;
         @(negedge clk);
         if (fire) done = 1'b1;
      end
      mem_req_valid = 1'b0;
      chk1("rd_accept", done, 1'b1);
      acc_cyc = cyc;
      if (done) begin
         exp_q.push_back(exp);
         cyc_q.push_back(cyc + LAT);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      chkint("drain", exp_q.size(), 0);
   endtask

   initial begin
      int a0, a1, a2, a3, ax;
      reset              = 1'b1;
      mem_req_valid      = 1'b0;
      mem_req_rw         = 1'b0;
      mem_req_addr       = '0;
      mem_req_data_valid = 1'b0;
      mem_req_data_bits  = '0;
      mem_req_data_mask  = '0;

      // Reset state: both readies held low even with a write presented
      @(negedge clk);
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      #1;
      chk1("rst_req_ready", mem_req_ready, 1'b0);
      chk1("rst_data_ready", mem_req_data_ready, 1'b0);
      chk1("rst_resp_valid", mem_resp_valid, 1'b0);
      chk128("rst_resp_data", mem_resp_data, 128'h0);
      @(negedge clk);
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      reset         = 1'b0;
      #1;
      chk1("idle_req_ready", mem_req_ready, 1'b1);
      chk1("idle_data_ready", mem_req_data_ready, 1'b0);

      // Stray data beat with no write request is not accepted
      mem_req_data_valid = 1'b1;
      #1;
      chk1("stray_data_ready", mem_req_data_ready, 1'b0);
      @(negedge clk);
      mem_req_data_valid = 1'b0;

      // 1: full-mask write then read next cycle, latency LAT
      do_write(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF);
      issue_read(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, ax);
      wait_drain();
      @(negedge clk);
      chk1("hold_valid_low", mem_resp_valid, 1'b0);
      chk128("hold_data", mem_resp_data, 128'h0123456789ABCDEF0123456789ABCDEF);

      // Zero-mask write leaves the line untouched
      do_write(28'h10, {128{1'b1}}, 16'h0000);
      issue_read(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, ax);
      wait_drain();

      // 2: low-4-byte mask over a zero line
      do_write(28'h30, 128'h0, 16'hFFFF);
      do_write(28'h30, {128{1'b1}}, 16'h000F);
      issue_read(28'h30, 128'h000000000000000000000000FFFFFFFF, ax);
      wait_drain();

      // 3: write request, data beat three cycles later
      mem_req_valid      = 1'b1;
      mem_req_rw         = 1'b1;
      mem_req_addr       = 28'h20;
      mem_req_data_valid = 1'b0;
      #1;
      chk1("w3_req_ready", mem_req_ready, 1'b1);
      chk1("w3_data_ready_req", mem_req_data_ready, 1'b1);
      @(negedge clk);
      mem_req_valid = 1'b0;
      #1;
      chk1("w3_wait_req_ready_1", mem_req_ready, 1'b0);
      chk1("w3_wait_data_ready", mem_req_data_ready, 1'b1);
      @(negedge clk);
      #1;
      chk1("w3_wait_req_ready_2", mem_req_ready, 1'b0);
      @(negedge clk);
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
      mem_req_data_mask  = 16'hFFFF;
      #1;
      chk1("w3_wait_req_ready_3", mem_req_ready, 1'b0);
      chk1("w3_commit_data_ready", mem_req_data_ready, 1'b1);
      @(negedge clk);
      mem_req_data_valid = 1'b0;
      #1;
      chk1("w3_back_idle", mem_req_ready, 1'b1);
      issue_read(28'h20, 128'hDEADBEEFCAFEF00D123456789ABCDEF0, ax);
      wait_drain();

      // 4: four back-to-back reads, responses on four consecutive cycles
      do_write(28'h0, 128'h000000A0, 16'hFFFF);
      do_write(28'h1, 128'h000000A1, 16'hFFFF);
      do_write(28'h2, 128'h000000A2, 16'hFFFF);
      do_write(28'h3, 128'h000000A3, 16'hFFFF);
      issue_read(28'h0, 128'h000000A0, a0);
      issue_read(28'h1, 128'h000000A1, a1);
      issue_read(28'h2, 128'h000000A2, a2);
      issue_read(28'h3, 128'h000000A3, a3);
      chkint("b2b_accept_span", a3 - a0, 3);
      wait_drain();

      // 5: reset two cycles after a read accept drops the response, keeps storage
      issue_read(28'h10, 128'h0, ax);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      cyc_q.delete();
      #1;
      chk1("r5_req_ready", mem_req_ready, 1'b0);
      @(negedge clk);
      chk1("r5_resp_valid", mem_resp_valid, 1'b0);
      chk128("r5_resp_data", mem_resp_data, 128'h0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk1("r5_no_resp", mem_resp_valid, 1'b0);
      end
      issue_read(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, ax);
      wait_drain();

      // 6: upper address bits alias onto the low index
      do_write(28'h1010, 128'h55555555666666667777777788888888, 16'hFFFF);
      issue_read(28'h0010, 128'h55555555666666667777777788888888, ax);
      do_write(28'h0010, {128{1'b1}}, 16'hF000);
      issue_read(28'h1010, 128'hFFFFFFFF666666667777777788888888, ax);
      wait_drain();

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
